call_stack: RTL and testbench

Parametrised hardware call/return stack for the pipelined processor, replacing the fixed push/pop storage the datapath uses for call and return addresses. It holds up to DEPTH entries of DATA_W bits in a circular register buffer. Overflow is handled by a selectable mode: drop the push, or overwrite the oldest entry. Sticky overflow/underflow flags and a flush input are provided so the hazard logic can discard speculative stack state.

---
 rtl/call_stack_pkg.sv | 6 +
 rtl/call_stack.sv | 107 ++++++++++
 tb/tb_call_stack.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/call_stack_pkg.sv
// Shared processor constants: program-counter width and the call-stack overflow modes.
package call_stack_pkg;
    localparam int PC_W       = 12;
    localparam int STACK_DROP = 0;
    localparam int STACK_WRAP = 1;
endpackage

// File: rtl/call_stack.sv
// Call/return address stack held in a circular flop array indexed by a wrapping top pointer.
// Overflow either drops the push or overwrites the oldest entry, selected by WRAP_ON_FULL.
module call_stack
    import call_stack_pkg::*;
#(
    parameter int DATA_W       = PC_W,
    parameter int DEPTH        = 8,
    parameter int WRAP_ON_FULL = STACK_DROP,
    parameter int CNT_W        = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] push_data,
    input  logic              flush,
    output logic [DATA_W-1:0] top,
    output logic [CNT_W-1:0]  count,
    output logic              empty,
    output logic              full,
    output logic              overflow,
    output logic              underflow
);
    localparam int SP_W = $clog2(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [SP_W-1:0]   r_sp;
    logic [CNT_W-1:0]  r_count;
    logic              r_ovf;
    logic              r_udf;

    logic              w_empty;
    logic              w_full;
    logic              w_wrap;
    logic [SP_W-1:0]   w_sp_inc;
    logic [SP_W-1:0]   w_sp_nxt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic              w_ovf_set;
    logic              w_udf_set;
    logic              w_we;
    logic [SP_W-1:0]   w_waddr;

    assign w_empty  = (r_count == '0);
    assign w_full   = (r_count == CNT_W'(DEPTH));
    assign w_wrap   = (WRAP_ON_FULL == STACK_WRAP);
    assign w_sp_inc = r_sp + SP_W'(1);

    always_comb begin
        w_sp_nxt  = r_sp;
        w_cnt_nxt = r_count;
        w_ovf_set = 1'b0;
        w_udf_set = 1'b0;
        w_we      = 1'b0;
        w_waddr   = w_sp_inc;
        if (push && !pop) begin
            if (!w_full || w_wrap) begin
                w_sp_nxt = w_sp_inc;
                w_we     = 1'b1;
            end
            if (!w_full) w_cnt_nxt = r_count + CNT_W'(1);
            else         w_ovf_set = 1'b1;
        end else if (pop && !push) begin
            if (!w_empty) begin
                w_sp_nxt  = r_sp - SP_W'(1);
                w_cnt_nxt = r_count - CNT_W'(1);
            end else begin
                w_udf_set = 1'b1;
            end
        end else if (push && pop) begin
            // Non-empty: replace the top in place. Empty: flag the pop, do the push.
            w_we = 1'b1;
            if (!w_empty) begin
                w_waddr = r_sp;
            end else begin
                w_udf_set = 1'b1;
                w_sp_nxt  = w_sp_inc;
                w_cnt_nxt = CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_sp    <= SP_W'(DEPTH - 1);
            r_count <= '0;
            r_ovf   <= 1'b0;
            r_udf   <= 1'b0;
        end else begin
            r_sp    <= w_sp_nxt;
            r_count <= w_cnt_nxt;
            r_ovf   <= r_ovf | w_ovf_set;
            r_udf   <= r_udf | w_udf_set;
        end
    end

    // Storage has no reset; an empty stack masks it on the top output.
    always_ff @(posedge clk) begin
        if (w_we && !reset && !flush) r_mem[w_waddr] <= push_data;
    end

    assign top       = w_empty ? '0 : r_mem[r_sp];
    assign count     = r_count;
    assign empty     = w_empty;
    assign full      = w_full;
    assign overflow  = r_ovf;
    assign underflow = r_udf;
endmodule

// File: tb/tb_call_stack.sv
// Directed bench for call_stack: drop-mode and wrap-mode instances share stimulus and are
// scored against a queue-based reference stack; test-plan values are also checked directly.
module tb_call_stack;
    import call_stack_pkg::*;

    localparam int DW = 12;
    localparam int DP = 8;
    localparam int CW = $clog2(DP + 1);

    typedef struct {
        logic [DW-1:0] top;
        logic [CW-1:0] cnt;
        logic          e, f, o, u;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset = 1'b0, push = 1'b0, pop = 1'b0, flush = 1'b0;
    logic [DW-1:0] push_data = '0;
    logic [DW-1:0] top0, top1;
    logic [CW-1:0] cnt0, cnt1;
    logic          e0, f0, o0, u0, e1, f1, o1, u1;

    int total = 0;
    int bad   = 0;

    exp_t          sb0[$], sb1[$];
    logic [DW-1:0] stk0[$], stk1[$];
    logic          mo0 = 0, mu0 = 0, mo1 = 0, mu1 = 0;

    always #5 clk = ~clk;

    call_stack #(.DATA_W(DW), .DEPTH(DP), .WRAP_ON_FULL(STACK_DROP)) u_drop (
        .clk(clk), .reset(reset), .push(push), .pop(pop), .push_data(push_data), .flush(flush),
        .top(top0), .count(cnt0), .empty(e0), .full(f0), .overflow(o0), .underflow(u0));

    call_stack #(.DATA_W(DW), .DEPTH(DP), .WRAP_ON_FULL(STACK_WRAP)) u_wrap (
        .clk(clk), .reset(reset), .push(push), .pop(pop), .push_data(push_data), .flush(flush),
        .top(top1), .count(cnt1), .empty(e1), .full(f1), .overflow(o1), .underflow(u1));

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model(inout logic [DW-1:0] s[$], inout logic ov, inout logic un,
                         input bit wrap, input bit rs, input bit fl, input bit pu,
                         input bit po, input logic [DW-1:0] d, output exp_t ex);
        if (rs || fl) begin
            s.delete(); ov = 0; un = 0;
        end else if (pu && po) begin
            if (s.size() == 0) begin un = 1; s.push_back(d); end
            else s[s.size()-1] = d;
        end else if (pu) begin
            if (s.size() < DP) s.push_back(d);
            else begin
                ov = 1;
                if (wrap) begin void'(s.pop_front()); s.push_back(d); end
            end
        end else if (po) begin
            if (s.size() == 0) un = 1;
            else void'(s.pop_back());
        end
        ex.top = (s.size() == 0) ? '0 : s[s.size()-1];
        ex.cnt = CW'(s.size());
        ex.e = (s.size() == 0);
        ex.f = (s.size() == DP);
        ex.o = ov;
        ex.u = un;
    endtask

    task automatic cmp(input string nm, input exp_t ex, input logic [DW-1:0] t,
                       input logic [CW-1:0] c, input logic e, f, o, u);
        chk({nm, ".top"}, int'(t), int'(ex.top));
        chk({nm, ".count"}, int'(c), int'(ex.cnt));
        chk({nm, ".empty"}, int'(e), int'(ex.e));
        chk({nm, ".full"}, int'(f), int'(ex.f));
        chk({nm, ".ovf"}, int'(o), int'(ex.o));
        chk({nm, ".udf"}, int'(u), int'(ex.u));
    endtask

    // One clock of stimulus; expected results are queued at drive time and retired after the edge.
    task automatic step(input bit rs, input bit fl, input bit pu, input bit po,
                        input logic [DW-1:0] d);
        exp_t ex;
        reset = rs; flush = fl; push = pu; pop = po; push_data = d;
        model(stk0, mo0, mu0, 1'b0, rs, fl, pu, po, d, ex); sb0.push_back(ex);
        model(stk1, mo1, mu1, 1'b1, rs, fl, pu, po, d, ex); sb1.push_back(ex);
        @(posedge clk);
        #1;
        reset = 0; flush = 0; push = 0; pop = 0;
        if (sb0.size() == 0 || sb1.size() == 0) begin
            total++; bad++;
            $display("FAIL scoreboard_empty observed=0 expected=1");
        end else begin
            ex = sb0.pop_front(); cmp("drop", ex, top0, cnt0, e0, f0, o0, u0);
            ex = sb1.pop_front(); cmp("wrap", ex, top1, cnt1, e1, f1, o1, u1);
        end
    endtask

    initial begin
        // reset state
        step(1, 0, 0, 0, '0);
        chk("rst.count", int'(cnt0), 0);
        chk("rst.top", int'(top0), 0);
        chk("rst.empty", int'(e0), 1);

        // basic LIFO
        step(0, 0, 1, 0, 12'h101);
        step(0, 0, 1, 0, 12'h102);
        step(0, 0, 1, 0, 12'h103);
        chk("lifo.top", int'(top0), 'h103);
        chk("lifo.count", int'(cnt0), 3);
        step(0, 0, 0, 1, '0); chk("pop1.top", int'(top0), 'h102);
        step(0, 0, 0, 1, '0); chk("pop2.top", int'(top0), 'h101);
        step(0, 0, 0, 1, '0);
        chk("pop3.top", int'(top0), 0);
        chk("pop3.empty", int'(e0), 1);
        chk("pop3.udf", int'(u0), 0);

        // overflow: drop vs wrap
        for (int i = 1; i <= 10; i++) begin
            step(0, 0, 1, 0, DW'(i));
            if (i == 9) begin
                chk("drop9.top", int'(top0), 8);
                chk("drop9.full", int'(f0), 1);
                chk("drop9.ovf", int'(o0), 1);
            end
        end
        chk("wrap10.top", int'(top1), 10);
        chk("wrap10.count", int'(cnt1), 8);
        chk("wrap10.ovf", int'(o1), 1);
        for (int i = 1; i <= 8; i++) begin
            step(0, 0, 0, 1, '0);
            if (i < 8) begin
                chk("droppop.top", int'(top0), 8 - i);
                chk("wrappop.top", int'(top1), 10 - i);
            end
        end
        chk("drop.empty", int'(e0), 1);
        chk("wrap.empty", int'(e1), 1);
        step(0, 1, 0, 0, '0);

        // simultaneous push+pop
        step(0, 0, 1, 0, 12'h010);
        step(0, 0, 1, 0, 12'h011);
        step(0, 0, 1, 1, 12'h2AA);
        chk("rep.top", int'(top0), 'h2AA);
        chk("rep.count", int'(cnt0), 2);
        chk("rep.udf", int'(u0), 0);
        step(0, 1, 0, 0, '0);
        step(0, 0, 1, 1, 12'h2AA);
        chk("pp_empty.count", int'(cnt0), 1);
        chk("pp_empty.top", int'(top0), 'h2AA);
        chk("pp_empty.udf", int'(u0), 1);
        step(0, 1, 0, 0, '0);

        // underflow sticky, then flush beats push
        step(0, 0, 0, 1, '0); chk("udf.set", int'(u0), 1);
        step(0, 0, 0, 0, '0); chk("udf.held", int'(u0), 1);
        step(0, 1, 1, 0, 12'h3C3);
        chk("flush.count", int'(cnt0), 0);
        chk("flush.udf", int'(u0), 0);

        // reset mid-operation with count=5 and overflow set
        for (int i = 0; i < 9; i++) step(0, 0, 1, 0, DW'(12'h200 + i));
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, '0);
        chk("pre.count", int'(cnt0), 5);
        chk("pre.ovf", int'(o0), 1);
        step(1, 0, 1, 0, 12'h7FF);
        chk("mrst.count", int'(cnt0), 0);
        chk("mrst.top", int'(top0), 0);
        chk("mrst.ovf", int'(o0), 0);
        chk("mrst.wrap_count", int'(cnt1), 0);
        step(0, 0, 1, 0, 12'h0AB);
        chk("post.top", int'(top0), 'h0AB);
        chk("post.count", int'(cnt0), 1);

        // randomized traffic against the reference stacks
        for (int i = 0; i < 200; i++)
            step(0, ($urandom_range(0, 31) == 0), $urandom_range(0, 1) == 1,
                 $urandom_range(0, 1) == 1, DW'($urandom));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
